// File: rtl/clock_divider_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_HALF        = DEF_CLK_FREQ_HZ / 2;

    // Wide enough for any supported CNT_W; callers truncate back to their width.
    localparam int HALF_CALC_W = 64;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_SYNC,
        CH_WRAP,
        CH_COUNT
    } ch_event_e;

    function automatic logic [HALF_CALC_W-1:0] clamp_half(input logic [HALF_CALC_W-1:0] half);
        return (half == '0) ? HALF_CALC_W'(1) : half;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow half-period, pending flag and
// registered clk_out/tick. Shadow value is applied only at a period boundary.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int               CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEF_HALF)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [HALF_CALC_W-1:0] RESET_HALF_WIDE = clamp_half(HALF_CALC_W'(DEFAULT_HALF));
    localparam logic [CNT_W-1:0]       RESET_HALF      = RESET_HALF_WIDE[CNT_W-1:0];

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       half;
    logic [CNT_W-1:0]       shadow;
    logic [HALF_CALC_W-1:0] wr_half_wide;
    ch_event_e              ev;

    assign wr_half_wide = clamp_half(HALF_CALC_W'(wr_half));

    // Priority: disable, then sync, then wrap; a wrap is suppressed by either.
    always_comb begin
        ev = CH_COUNT;
        if (!enable) begin
            ev = CH_IDLE;
        end else if (sync) begin
            ev = CH_SYNC;
        end else if (cnt >= half - CNT_W'(1)) begin
            ev = CH_WRAP;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            half    <= RESET_HALF;
            shadow  <= RESET_HALF;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            case (ev)
                CH_IDLE, CH_SYNC: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    tick    <= 1'b0;
                end
                CH_WRAP: begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                end
                default: begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                end
            endcase

            if (pending && (ev != CH_COUNT)) begin
                half    <= shadow;
                pending <= 1'b0;
            end

            // Writes are only accepted while nothing is pending, so this never
            // collides with the shadow application above.
            if (wr_en) begin
                shadow  <= wr_half_wide[CNT_W-1:0];
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: configuration handshake decode,
// out-of-range error strobe and NUM_CH independent divider channels.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int               CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int               NUM_CH       = 4,
    parameter int               CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLK_FREQ_HZ / 2),
    localparam int              CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              sync_all,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int             CH_SPAN  = 1 << CH_W;
    localparam logic [CH_W:0]  NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0]  pending;
    logic [CH_SPAN-1:0] pending_span;
    logic               cfg_in_range;
    logic               cfg_accept;

    // Pad pending flags to the full cfg_ch code space so any code indexes safely.
    assign pending_span = CH_SPAN'(pending);
    assign cfg_in_range = {1'b0, cfg_ch} < NUM_CH_L;
    assign cfg_ready    = cfg_in_range ? ~pending_span[cfg_ch] : 1'b1;
    assign cfg_accept   = cfg_valid && cfg_ready;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_accept && !cfg_in_range;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;

        assign wr_en = cfg_accept && cfg_in_range && (cfg_ch == CH_W'(i));

        clock_divider_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_channel (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .enable   (ch_enable[i]),
            .sync     (sync_all),
            .wr_en    (wr_en),
            .wr_half  (cfg_half),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .pending  (pending[i])
        );
    end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Multi-channel programmable clock divider for the messenger design, running on CLOCK_50. Each of NUM_CH channels produces a 50 % duty divided clock and a one-cycle tick strobe (for use as a clock enable) from a runtime-loadable half-period count. Divisor changes are double-buffered and take effect only at the channel's period boundary, so outputs never glitch. A global sync input phase-aligns all channels.

## Interface
- CLK_FREQ_HZ, 50000000, input clock frequency (documentation and default derivation only)
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 32, counter and half-period width
- DEFAULT_HALF, CLK_FREQ_HZ/2, half-period loaded into every channel at reset (1 Hz output)
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ch_enable  in  NUM_CH  per-channel run enable
- sync_all  in  1  one-cycle pulse: restart all channels in phase
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_half  in  CNT_W  new half-period in CLOCK_50 cycles
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch >= NUM_CH
- clk_out  out  NUM_CH  divided clocks, period 2*H cycles
- tick  out  NUM_CH  one-cycle strobe per half-period (each clk_out edge)

## Operation
- Per channel: active half-period H, shadow value S, pending flag P, counter C.
- Effective H = max(cfg_half, 1); a write of 0 is stored as 1.
- Running (ch_enable=1): C increments each cycle; when C >= H-1 (wrap): C<=0, clk_out toggles, tick=1 for that cycle. If P=1 at wrap: H<=S, P<=0.
- Disabled (ch_enable=0): C held 0, clk_out forced 0, tick 0; if P=1, H<=S and P<=0 immediately.
- On ch_enable rise: first wrap occurs H cycles later; clk_out rises then.
- Config handshake: cfg_ready = ~P[cfg_ch] (combinational); always 1 when cfg_ch >= NUM_CH. Accepted write: S<=cfg_half clamped, P<=1. Out-of-range channel: write dropped, cfg_err pulses next cycle.
- sync_all: every channel C<=0, clk_out<=0, tick 0, and any P already set is applied (H<=S, P<=0). Disabled channels unaffected beyond pending application.
- Simultaneous events:
  - Write accepted on the wrap cycle of the target: wrap uses old H; new value pending, applied at the following wrap.
  - Write accepted on a sync_all cycle: sync applies prior P only; new write becomes pending.
  - sync_all and wrap same cycle: sync wins, no tick, clk_out 0.
  - Disable and wrap same cycle: disable wins.

## Timing
- Reset values: clk_out 0, tick 0, cfg_err 0, C 0, H = S = DEFAULT_HALF, P 0; cfg_ready 1.
- All outputs registered except cfg_ready.
- tick asserted in the same cycle as the clk_out edge it marks (both registered from the wrap decision).
- H=1: clk_out toggles every cycle (25 MHz), tick constantly 1.
- Worst-case config latency: H cycles to apply after acceptance; cfg_ready low for that span.
- Counter arithmetic CNT_W-bit unsigned; H-1 computed at CNT_W bits, no overflow as H>=1.
- Reset asserted mid-period: outputs drop to reset values asynchronously; count restarts from 0 after release.

## Structure
- Package clock_divider_pkg: CNT_W default, DEFAULT_HALF default, function clamp_half (0 -> 1).
- Sub-module clock_divider_channel: one channel (C, H, S, P, clk_out, tick), instantiated NUM_CH times by generate; top holds handshake decode and cfg_err.

## Test plan
- Reset release, ch_enable=4'b0001, DEFAULT_HALF overridden to 5 -> ch0 clk_out period 10 cycles, first rise 5 cycles after enable, tick every 5 cycles; other channels 0.
- Write ch1 half=3 while running at 5 -> cfg_ready for ch1 low until next ch1 wrap; subsequent half-periods exactly 3; no short pulse on clk_out.
- Write half=0 to ch2 -> clk_out toggles every cycle, tick held 1.
- Channels at halves 3 and 7 running, pulse sync_all -> both clk_out 0 that cycle, both rise exactly 3 and 7 cycles later.
- Write with cfg_ch=5 when NUM_CH=4 -> accepted (cfg_ready 1), cfg_err pulse one cycle, no channel changes.
- Assert reset mid-period with clk_out=1 -> clk_out 0 same cycle without clock edge; after release, H back to DEFAULT_HALF.
